bank_access_arbiter: RTL and testbench
======================================

Name: bank_access_arbiter

Overview:
- Shares the 10-bank array memory between NREQ requesters.
- Round-robin arbitration grants one access per cycle and drives one-hot mem_csel, address and data to the banks.
- Steers returned read data back to the issuing requester with a tag.
- Sits between the client ports and the bank array; the bank array never sees more than one active csel bit.

Parameters:
- NREQ, 4, number of requesters (2..8)
- NBANK, 10, number of banks; width of mem_csel
- AW, 12, word address width inside a bank
- DW, 32, data width
- RD_LAT, 1, cycles from mem_csel issue to valid mem_r_data (1..4)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_we  in  NREQ  1 = write, 0 = read
- req_bank  in  NREQ*4  bank index per requester
- req_addr  in  NREQ*AW  word address per requester
- req_wdata  in  NREQ*DW  write data per requester
- rsp_valid  out  1  read response valid, 1-cycle pulse
- rsp_id  out  3  requester index of the response
- rsp_data  out  DW  read data
- err  out  1  1-cycle pulse: accepted request had req_bank >= NBANK
- mem_csel  out  NBANK  one-hot bank select; 0 when idle
- mem_we  out  1  write strobe for the selected bank
- mem_w_addr  out  AW  write address
- mem_w_data  out  DW  write data
- mem_r_addr  out  AW  read address
- mem_r_data  in  DW  muxed read data from the selected bank
- grant_cnt  out  NREQ*16  per-requester grant counters (see Optional Feature)

Behaviour:
- Reset (rst=0, async): all outputs 0, rr_ptr=0, read-tracking pipeline cleared.
- Reset mid-operation discards in-flight reads; no rsp_valid is produced for them after release.
- Arbitration (combinational):
  - Scan requesters from rr_ptr upward, wrapping; the first with req_valid=1 wins.
  - req_ready[winner]=1; all other bits 0. No valid requests -> req_ready=0.
  - An accepted request is one with req_valid & req_ready.
- On acceptance, rr_ptr <= (winner+1) mod NREQ. No acceptance -> rr_ptr holds.
- Issue stage (registered, 1 cycle after acceptance):
  - mem_csel = 1<<req_bank; mem_we = req_we.
  - Write: mem_w_addr/mem_w_data = request fields; mem_r_addr=0.
  - Read: mem_r_addr = req_addr; mem_w_addr=0, mem_w_data=0.
  - Idle cycle: mem_csel=0, mem_we=0, all addr/data 0.
- Bad bank (req_bank >= NBANK):
  - Request is still accepted; err pulses in the issue cycle; mem_csel=0.
  - A bad-bank read still returns rsp_valid with rsp_data=0 and the correct rsp_id.
- Read tracking:
  - A (valid, id, bad) token shifts through an RD_LAT-deep pipeline starting at the issue cycle.
  - When the token exits: rsp_valid=1, rsp_id=id, rsp_data = bad ? 0 : mem_r_data, all registered.
  - Read latency acceptance->rsp_valid = RD_LAT+1 cycles.
- Throughput: one access per cycle; back-to-back reads to any banks, including the same bank, are fully pipelined.
- Writes produce no response.
- Ordering: a read issued after a write to the same bank/address in a later cycle returns the new data; the bank array is write-before-read across cycles.
- Requesters must hold req_* stable until accepted; dropping req_valid before acceptance is permitted.

Optional Feature:
- Macro: BANK_ARB_PERF_EN.
- Defined:
  - Each 16-bit slice of grant_cnt counts accepted requests for that requester.
  - Counters saturate at 0xFFFF and are cleared by reset.
- Undefined: grant_cnt is tied to 0 and the counter logic is absent.

Test Plan:
- Single read: requester 2 reads bank 3, addr 0x010, memory model returns 0xDEADBEEF.
  - -> req_ready=0100 in the same cycle; mem_csel=0x008 next cycle.
  - -> rsp_valid with rsp_id=2, rsp_data=0xDEADBEEF exactly RD_LAT+1 cycles after acceptance.
- Fairness: all 4 requesters hold reads continuously for 8 cycles.
  - -> grant order 0,1,2,3,0,1,2,3, one grant per cycle.
  - -> 8 responses in issue order.
- Write then read: requester 0 writes 0x12345678 to bank 9 addr 0xFFF, then requester 1 reads the same location.
  - -> mem_we=1 with mem_csel=0x200, then rsp_id=1, rsp_data=0x12345678.
- Bad bank: requester 3 reads req_bank=12.
  - -> accepted; err pulses; mem_csel=0.
  - -> rsp_valid with rsp_id=3, rsp_data=0.
- Reset mid-read: issue 3 reads, assert rst low 1 cycle after the last acceptance.
  - -> all outputs 0 immediately; no rsp_valid after release; rr_ptr restarts at 0.
- With BANK_ARB_PERF_EN: 5 grants to requester 1 -> grant_cnt[31:16]=5.
  - -> preloaded 0xFFFF stays 0xFFFF after a further grant.

Source files
------------

// File: rtl/bank_access_arbiter.sv
// bank_access_arbiter: round-robin arbiter sharing a banked memory between NREQ requesters, with tagged read return.
// Define BANK_ARB_PERF_EN to enable the saturating per-requester grant counters on grant_cnt.
module bank_access_arbiter #(
  parameter int NREQ   = 4,
  parameter int NBANK  = 10,
  parameter int AW     = 12,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*4-1:0]    req_bank,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_id,
  output logic [DW-1:0]        rsp_data,
  output logic                 err,
  output logic [NBANK-1:0]     mem_csel,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_w_addr,
  output logic [DW-1:0]        mem_w_data,
  output logic [AW-1:0]        mem_r_addr,
  input  logic [DW-1:0]        mem_r_data,
  output logic [NREQ*16-1:0]   grant_cnt
);
  logic [2:0] rr_ptr, win;
  logic found, acc, bad, we;
  logic [3:0] bank;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [RD_LAT-1:0] tok_v, tok_bad;
  logic [RD_LAT-1:0][2:0] tok_id;
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[(int'(rr_ptr) + i) % NREQ]) begin
        found = 1'b1;
        win = 3'((int'(rr_ptr) + i) % NREQ);
      end
    end
  end
  // no grants while reset is held, so every output reads zero during reset
  assign acc = found & rst;
  assign req_ready = acc ? (NREQ'(1) << win) : '0;
  assign we = req_we[win];
  assign bank = req_bank[win*4 +: 4];
  assign addr = req_addr[win*AW +: AW];
  assign wdata = req_wdata[win*DW +: DW];
  assign bad = int'(bank) >= NBANK;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      mem_csel <= '0;
      mem_we <= 1'b0;
      mem_w_addr <= '0;
      mem_w_data <= '0;
      mem_r_addr <= '0;
      err <= 1'b0;
      tok_v <= '0;
      tok_bad <= '0;
      tok_id <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
    end else begin
      if (acc) rr_ptr <= 3'((int'(win) + 1) % NREQ);
      mem_csel <= (acc && !bad) ? (NBANK'(1) << bank) : '0;
      mem_we <= acc & we;
      mem_w_addr <= (acc && we) ? addr : '0;
      mem_w_data <= (acc && we) ? wdata : '0;
      mem_r_addr <= (acc && !we) ? addr : '0;
      err <= acc & bad;
      // read token travels alongside the bank's read latency
      tok_v[0] <= acc & ~we;
      tok_bad[0] <= bad;
      tok_id[0] <= win;
      for (int i = 1; i < RD_LAT; i++) begin
        tok_v[i] <= tok_v[i-1];
        tok_bad[i] <= tok_bad[i-1];
        tok_id[i] <= tok_id[i-1];
      end
      rsp_valid <= tok_v[RD_LAT-1];
      rsp_id <= tok_v[RD_LAT-1] ? tok_id[RD_LAT-1] : '0;
      rsp_data <= (tok_v[RD_LAT-1] && !tok_bad[RD_LAT-1]) ? mem_r_data : '0;
    end
  end
`ifdef BANK_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) grant_cnt <= '0;
    else
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i] && grant_cnt[i*16 +: 16] != 16'hFFFF) grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
  end
`else
  assign grant_cnt = '0;
`endif
endmodule

// File: tb/tb_bank_access_arbiter.sv
// tb_bank_access_arbiter: vector table, directed sequences and randomized traffic against a transaction-level model.
module tb_bank_access_arbiter;
  localparam int NREQ = 4, NBANK = 10, AW = 12, DW = 32, RD_LAT = 1;
  logic clk = 1'b0, rst = 1'b0;
  logic [NREQ-1:0] req_valid = '0, req_ready, req_we = '0;
  logic [NREQ*4-1:0] req_bank = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic rsp_valid, err, mem_we;
  logic [2:0] rsp_id;
  logic [DW-1:0] rsp_data, mem_w_data;
  logic [DW-1:0] mem_r_data = '0;
  logic [NBANK-1:0] mem_csel;
  logic [AW-1:0] mem_w_addr, mem_r_addr;
  logic [NREQ*16-1:0] grant_cnt;

  always #5 clk = ~clk;

  bank_access_arbiter #(.NREQ(NREQ), .NBANK(NBANK), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_bank(req_bank), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .err(err), .mem_csel(mem_csel), .mem_we(mem_we),
    .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data), .mem_r_addr(mem_r_addr),
    .mem_r_data(mem_r_data), .grant_cnt(grant_cnt));

  function automatic logic [DW-1:0] base(int k);
    return (k == 3*4096 + 16) ? 32'hDEADBEEF : (32'h5A00_0000 ^ 32'(k));
  endfunction

  // bank array: writes commit mid-cycle, read data presented before the sampling edge
  logic [DW-1:0] dmem [int];
  always @(negedge clk) begin
    int b;
    b = -1;
    for (int i = 0; i < NBANK; i++) if (mem_csel[i]) b = i;
    if (b >= 0 && mem_we) dmem[b*4096 + int'(mem_w_addr)] = mem_w_data;
    mem_r_data = (b < 0) ? '0 : dmem.exists(b*4096 + int'(mem_r_addr)) ? dmem[b*4096 + int'(mem_r_addr)] : base(b*4096 + int'(mem_r_addr));
  end

  int nchk = 0, nfail = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // transaction-level reference
  typedef struct {int due; int id; logic [DW-1:0] d;} rsp_t;
  rsp_t q[$];
  logic [DW-1:0] rmem [int];
  int rr = 0, cyc = 0, last_win = -1;
  int cnt [NREQ];
  logic [NBANK-1:0] e_csel;
  logic e_we, e_err;
  logic [AW-1:0] e_wa, e_ra;
  logic [DW-1:0] e_wd;
  logic [NREQ-1:0] ready_s;

  task automatic model_reset();
    q.delete();
    rr = 0;
    last_win = -1;
    e_csel = '0; e_we = 0; e_err = 0; e_wa = '0; e_ra = '0; e_wd = '0;
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
  endtask

  task automatic step();
    int w, b, k;
    logic [NREQ*16-1:0] gc;
    @(negedge clk);
    w = -1;
    for (int i = 0; i < NREQ; i++) if (w < 0 && req_valid[(rr+i)%NREQ]) w = (rr+i)%NREQ;
    ready_s = req_ready;
    chk("req_ready", 64'(req_ready), (w < 0) ? 64'd0 : 64'(1) << w);
    chk("mem_csel", 64'(mem_csel), 64'(e_csel));
    chk("mem_we", 64'(mem_we), 64'(e_we));
    chk("mem_w_addr", 64'(mem_w_addr), 64'(e_wa));
    chk("mem_w_data", 64'(mem_w_data), 64'(e_wd));
    chk("mem_r_addr", 64'(mem_r_addr), 64'(e_ra));
    chk("err", 64'(err), 64'(e_err));
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
      chk("rsp_data", 64'(rsp_data), 64'(q[0].d));
      void'(q.pop_front());
    end else chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
    gc = '0;
`ifdef BANK_ARB_PERF_EN
    for (int i = 0; i < NREQ; i++) gc[i*16 +: 16] = 16'(cnt[i]);
`endif
    chk("grant_cnt", 64'(grant_cnt), 64'(gc));
    last_win = w;
    if (w >= 0) begin
      b = int'(req_bank[w*4 +: 4]);
      k = b*4096 + int'(req_addr[w*AW +: AW]);
      e_csel = (b < NBANK) ? NBANK'(1) << b : '0;
      e_we = req_we[w];
      e_err = b >= NBANK;
      e_wa = req_we[w] ? req_addr[w*AW +: AW] : '0;
      e_wd = req_we[w] ? req_wdata[w*DW +: DW] : '0;
      e_ra = req_we[w] ? '0 : req_addr[w*AW +: AW];
      if (req_we[w] && b < NBANK) rmem[k] = req_wdata[w*DW +: DW];
      if (!req_we[w]) q.push_back('{cyc + RD_LAT + 1, w, (b >= NBANK) ? '0 : rmem.exists(k) ? rmem[k] : base(k)});
      if (cnt[w] < 16'hFFFF) cnt[w]++;
      rr = (w + 1) % NREQ;
    end else begin
      e_csel = '0; e_we = 0; e_err = 0; e_wa = '0; e_ra = '0; e_wd = '0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic v, logic w, int b, int a, logic [DW-1:0] d);
    req_valid[i] = v;
    req_we[i] = w;
    req_bank[i*4 +: 4] = 4'(b);
    req_addr[i*AW +: AW] = AW'(a);
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 0);
    chk({tag, "_mem_csel"}, 64'(mem_csel), 0);
    chk({tag, "_mem_we"}, 64'(mem_we), 0);
    chk({tag, "_mem_w_addr"}, 64'(mem_w_addr), 0);
    chk({tag, "_mem_w_data"}, 64'(mem_w_data), 0);
    chk({tag, "_mem_r_addr"}, 64'(mem_r_addr), 0);
    chk({tag, "_err"}, 64'(err), 0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 0);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 0);
    chk({tag, "_grant_cnt"}, 64'(grant_cnt), 0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  typedef struct {logic [3:0] v; int bank; logic [3:0] rdy; logic [NBANK-1:0] csel; logic e;} vec_t;
  vec_t tbl [8];

  initial begin
    tbl[0] = '{4'b1111, 1, 4'b0001, 10'h002, 1'b0};
    tbl[1] = '{4'b1111, 2, 4'b0010, 10'h004, 1'b0};
    tbl[2] = '{4'b0001, 0, 4'b0001, 10'h001, 1'b0};
    tbl[3] = '{4'b0000, 5, 4'b0000, 10'h000, 1'b0};
    tbl[4] = '{4'b1001, 9, 4'b1000, 10'h200, 1'b0};
    tbl[5] = '{4'b0110, 12, 4'b0010, 10'h000, 1'b1};
    tbl[6] = '{4'b0100, 7, 4'b0100, 10'h080, 1'b0};
    tbl[7] = '{4'b0011, 15, 4'b0001, 10'h000, 1'b1};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // fairness: everyone keeps a read pending for 8 cycles
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, i + 4, 32 + i, '0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("fair_order", 64'(ready_s), 64'(1) << (k % NREQ));
    end
    req_valid = '0;
    repeat (3) step();

    // arbitration vectors from rr_ptr = 0
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, tbl[k].v[i], 0, tbl[k].bank, k, '0);
      step();
      chk("tbl_ready", 64'(ready_s), 64'(tbl[k].rdy));
      chk("tbl_csel", 64'(mem_csel), 64'(tbl[k].csel));
      chk("tbl_err", 64'(err), 64'(tbl[k].e));
    end
    req_valid = '0;
    repeat (3) step();

    // single read from requester 2
    set_req(2, 1, 0, 3, 'h010, '0);
    step();
    chk("single_ready", 64'(ready_s), 64'b0100);
    chk("single_csel", 64'(mem_csel), 64'h008);
    req_valid = '0;
    step();
    chk("single_rsp_valid", 64'(rsp_valid), 1);
    chk("single_rsp_id", 64'(rsp_id), 2);
    chk("single_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
    step();

    // write then read the same location
    set_req(0, 1, 1, 9, 'hFFF, 32'h12345678);
    step();
    chk("wr_we", 64'(mem_we), 1);
    chk("wr_csel", 64'(mem_csel), 64'h200);
    req_valid = '0;
    set_req(1, 1, 0, 9, 'hFFF, '0);
    step();
    req_valid = '0;
    step();
    chk("rd_rsp_valid", 64'(rsp_valid), 1);
    chk("rd_rsp_id", 64'(rsp_id), 1);
    chk("rd_rsp_data", 64'(rsp_data), 64'h12345678);
    step();

    // bad bank read
    set_req(3, 1, 0, 12, 5, '0);
    step();
    chk("bad_ready", 64'(ready_s), 64'b1000);
    chk("bad_err", 64'(err), 1);
    chk("bad_csel", 64'(mem_csel), 0);
    req_valid = '0;
    step();
    chk("bad_rsp_valid", 64'(rsp_valid), 1);
    chk("bad_rsp_id", 64'(rsp_id), 3);
    chk("bad_rsp_data", 64'(rsp_data), 0);
    step();

    // reset while reads are in flight
    for (int i = 0; i < 3; i++) set_req(i, 1, 0, i, i, '0);
    repeat (3) step();
    req_valid = '0;
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    repeat (4) step();
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 1, i, '0);
    step();
    chk("post_reset_ptr", 64'(ready_s), 64'b0001);
    req_valid = '0;
    repeat (3) step();

    // randomized traffic with hold-until-accepted requesters
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || last_win == i) begin
          if ($urandom_range(1, 0) == 1) set_req(i, 1, 1'($urandom_range(1, 0)), $urandom_range(11, 0), $urandom_range(7, 0), $urandom);
          else req_valid[i] = 1'b0;
        end else if ($urandom_range(7, 0) == 0) req_valid[i] = 1'b0;
      end
      step();
    end
    req_valid = '0;
    repeat (4) step();
    chk("drain_empty", 64'(q.size()), 0);

    // grant counting for requester 1
    do_reset();
    set_req(1, 1, 0, 2, 0, '0);
    repeat (5) step();
`ifdef BANK_ARB_PERF_EN
    chk("cnt_five", 64'(grant_cnt[31:16]), 5);
    repeat (65535) @(posedge clk);
    #1;
    chk("cnt_sat", 64'(grant_cnt[31:16]), 64'hFFFF);
    @(posedge clk);
    #1;
    chk("cnt_sat_hold", 64'(grant_cnt[31:16]), 64'hFFFF);
`else
    chk("cnt_absent", 64'(grant_cnt), 0);
`endif
    req_valid = '0;
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
